pc_sequencer: RTL and testbench

Controls the 16-bit fetch program counter of the pipelined CPU; IF stage consumes pc_o.
Selects next PC each cycle from increment, branch target or jump target; applies load-use stalls; inserts post-redirect flush bubbles.
Holds a boot-wait window after reset release.
Sits between hazard/branch-resolution logic (ID/EX) and instruction memory.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_next_mux.sv | 34 +++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch PC sequencer: FSM states and next-PC select codes.
package pc_seq_pkg;

  localparam int PC_W_DEF = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_JMP  = 2'd3
  } sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Priority next-PC select: branch (older instr) > jump > stall > increment.
// Pure datapath; the FSM in pc_sequencer decides whether the choice is used.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            stall,
  output sel_t            sel,
  output logic [PC_W-1:0] nxt_pc
);

  // Priority encode requests into a select code and the matching PC
  always_comb begin
    sel    = SEL_INC;
    nxt_pc = pc + PC_W'(1);
    if (br_taken) begin
      sel    = SEL_BR;
      nxt_pc = br_target;
    end else if (jmp) begin
      sel    = SEL_JMP;
      nxt_pc = jmp_target;
    end else if (stall) begin
      sel    = SEL_HOLD;
      nxt_pc = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot wait, run/increment, load-use hold, post-redirect flush.
// Optional build macro PC_STALL_CNT_EN adds stall_cnt_o (saturating HOLD-cycle count).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC    = '0,
  parameter int              BOOT_WAIT    = 2,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_step,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  output logic [PC_W-1:0] pc_o,
`ifdef PC_STALL_CNT_EN
  output logic [15:0]     stall_cnt_o,
`endif
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic [1:0]      state_o
);

  localparam int BW = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_INIT  = BW'(BOOT_WAIT - 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, nxt_pc;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  sel_t            sel;
  logic            redirect;

  pc_next_mux #(.PC_W(PC_W)) u_mux (
    .pc         (pc_q),
    .br_taken   (br_taken_i),
    .br_target  (br_target_i),
    .jmp        (jmp_i),
    .jmp_target (jmp_target_i),
    .stall      (stall_i),
    .sel        (sel),
    .nxt_pc     (nxt_pc)
  );

  assign redirect = (sel == SEL_BR) || (sel == SEL_JMP);

  // State register; reset wins over en_step and every request
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      bcnt_q  <= BOOT_INIT;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state / PC; everything holds when en_step is low
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
    if (en_step) begin
      if (state_q == BOOT) begin
        if (bcnt_q == '0) state_d = RUN;
        else              bcnt_d  = bcnt_q - BW'(1);
      end else if (redirect) begin
        // target lands immediately; a redirect inside FLUSH restarts the window
        pc_d    = nxt_pc;
        state_d = FLUSH;
        fcnt_d  = FLUSH_INIT;
      end else begin
        case (state_q)
          RUN: begin
            if (sel == SEL_HOLD) state_d = HOLD;
            else                 pc_d    = nxt_pc;
          end
          // release re-enters RUN without advancing so the held PC is fetched
          HOLD: if (!stall_i) state_d = RUN;
          FLUSH: begin
            if (fcnt_q == '0) state_d = RUN;
            else              fcnt_d  = fcnt_q - FW'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PC_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of enabled cycles spent in HOLD
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (en_step && state_q == HOLD && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign pc_o          = pc_q;
  assign state_o       = state_q;
  assign fetch_valid_o = (state_q == RUN);
  assign flush_o       = (state_q == FLUSH);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: dut1 uses default FLUSH_CYCLES=1,
// dut2 uses FLUSH_CYCLES=3; both see the same stimulus.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, en_step, stall_i, br_taken_i, jmp_i;
  logic [15:0] br_target_i, jmp_target_i;
  logic [15:0] pc1, pc2;
  logic        fv1, fv2, fl1, fl2;
  logic [1:0]  st1, st2;
`ifdef PC_STALL_CNT_EN
  logic [15:0] sc1, sc2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut1 (
    .clk(clk), .rst(rst), .en_step(en_step), .stall_i(stall_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
    .pc_o(pc1),
`ifdef PC_STALL_CNT_EN
    .stall_cnt_o(sc1),
`endif
    .fetch_valid_o(fv1), .flush_o(fl1), .state_o(st1)
  );

  pc_sequencer #(.FLUSH_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .en_step(en_step), .stall_i(stall_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .jmp_i(jmp_i), .jmp_target_i(jmp_target_i),
    .pc_o(pc2),
`ifdef PC_STALL_CNT_EN
    .stall_cnt_o(sc2),
`endif
    .fetch_valid_o(fv2), .flush_o(fl2), .state_o(st2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // pc, state, fetch_valid, flush of dut1 in one go
  task automatic chk1(input string tag, input logic [15:0] pc, input logic [1:0] st);
    check({tag, ".pc"}, 32'(pc1), 32'(pc));
    check({tag, ".st"}, 32'(st1), 32'(st));
    check({tag, ".fv"}, 32'(fv1), 32'(st == 2'd1));
    check({tag, ".fl"}, 32'(fl1), 32'(st == 2'd3));
  endtask

  task automatic chk2(input string tag, input logic [15:0] pc, input logic [1:0] st);
    check({tag, ".pc"}, 32'(pc2), 32'(pc));
    check({tag, ".st"}, 32'(st2), 32'(st));
    check({tag, ".fv"}, 32'(fv2), 32'(st == 2'd1));
    check({tag, ".fl"}, 32'(fl2), 32'(st == 2'd3));
  endtask

  task automatic jump(input logic [15:0] t);
    jmp_i = 1'b1; jmp_target_i = t;
    step();
    jmp_i = 1'b0; jmp_target_i = '0;
  endtask

  initial begin
    rst = 1'b0; en_step = 1'b1; stall_i = 1'b0;
    br_taken_i = 1'b0; br_target_i = '0; jmp_i = 1'b0; jmp_target_i = '0;

    // 1: reset, boot wait, first fetches
    step(); step(); step();
    chk1("rst", 16'h0000, 2'd0);
`ifdef PC_STALL_CNT_EN
    check("rst.scnt", 32'(sc1), 32'd0);
`endif
    rst = 1'b1;
    step(); chk1("boot1", 16'h0000, 2'd0);
    step(); chk1("run0", 16'h0000, 2'd1);
    step(); chk1("run1", 16'h0001, 2'd1);
    step(); chk1("run2", 16'h0002, 2'd1);

    // 2: load-use stall at 0010
    jump(16'h0010); chk1("j10", 16'h0010, 2'd3);
    step();         chk1("j10run", 16'h0010, 2'd1);
    stall_i = 1'b1;
    step(); chk1("hold1", 16'h0010, 2'd2);
    step(); chk1("hold2", 16'h0010, 2'd2);
    step(); chk1("hold3", 16'h0010, 2'd2);
    stall_i = 1'b0;
    step(); chk1("rel", 16'h0010, 2'd1);
    step(); chk1("relinc", 16'h0011, 2'd1);

    // 3: branch beats jump in the same cycle
    jump(16'h0020); step(); chk1("at20", 16'h0020, 2'd1);
    br_taken_i = 1'b1; br_target_i = 16'h0100;
    jmp_i = 1'b1; jmp_target_i = 16'h0200;
    step(); chk1("brj", 16'h0100, 2'd3);
    br_taken_i = 1'b0; jmp_i = 1'b0;
    step(); chk1("brj.run", 16'h0100, 2'd1);
    step(); chk1("brj.inc", 16'h0101, 2'd1);

    // 5: wrap and freeze (requests present while frozen must be ignored)
    jump(16'hFFFF); step(); chk1("atFFFF", 16'hFFFF, 2'd1);
    step(); chk1("wrap", 16'h0000, 2'd1);
    en_step = 1'b0; stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      step(); chk1("frz", 16'h0000, 2'd1);
    end
    en_step = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;

    // 4: re-sync both DUTs, then redirect inside a 3-cycle flush (dut2)
    rst = 1'b0; step(); rst = 1'b1;
    step(); step(); chk2("d2run", 16'h0000, 2'd1);
    jump(16'h0300); chk2("d2j", 16'h0300, 2'd3);
    step();         chk2("d2fl2", 16'h0300, 2'd3);
    br_taken_i = 1'b1; br_target_i = 16'h0400;
    step(); chk2("d2br", 16'h0400, 2'd3);
    br_taken_i = 1'b0; br_target_i = '0;
    step(); chk2("d2fl_b", 16'h0400, 2'd3);
    step(); chk2("d2fl_c", 16'h0400, 2'd3);
    step(); chk2("d2run4", 16'h0400, 2'd1);
    step(); chk2("d2inc", 16'h0401, 2'd1);
    chk1("d1track", 16'h0403, 2'd1);

    // 6: reset during HOLD
    stall_i = 1'b1;
    step(); chk1("h6a", 16'h0403, 2'd2);
    step(); step(); chk1("h6b", 16'h0403, 2'd2);
`ifdef PC_STALL_CNT_EN
    check("scnt2", 32'(sc1), 32'd2);
`endif
    rst = 1'b0;
    step(); chk1("rsthold", 16'h0000, 2'd0);
`ifdef PC_STALL_CNT_EN
    check("scnt.clr", 32'(sc1), 32'd0);
`endif
    rst = 1'b1; stall_i = 1'b0;
    step(); chk1("reboot", 16'h0000, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
